// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between two requesters, the round-robin mux controller and its downstream sink.
// The master modport is the requester/sink side; the slave modport is the arbiter.
interface mux_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic             out_ready;
    logic             sel;
    logic             grant0;
    logic             grant1;
    logic             ack0;
    logic             ack1;
    logic [WIDTH-1:0] q;
    logic             q_valid;

    modport master (
        output req0, req1, i0, i1, out_ready,
        input  sel, grant0, grant1, ack0, ack1, q, q_valid
    );

    modport slave (
        input  req0, req1, i0, i1, out_ready,
        output sel, grant0, grant1, ack0, ack1, q, q_valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux: drives the select, grants, accept strobes and a one-slot output register.
// Define MUX_RR_FIXED_PRIORITY_EN for fixed priority (port 0 wins, port 1 preempted at beat boundaries).
module mux_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    localparam logic [3:0] LAST_COUNT = 4'(MAX_BURST - 1);

    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("mux_rr_arbiter: MAX_BURST=%0d outside 1..15", MAX_BURST);
    end

    state_t           state, state_nxt;
    logic [3:0]       count, count_nxt;
    logic [WIDTH-1:0] q_r;
    logic             q_valid_r;
    logic             slot_free;
    logic             fire0, fire1;
    logic             tie_to_1;
    logic             limit0, limit1;

    assign slot_free = !q_valid_r || bus.out_ready;
    assign fire0     = (state == GNT0) && bus.req0 && slot_free;
    assign fire1     = (state == GNT1) && bus.req1 && slot_free;

`ifdef MUX_RR_FIXED_PRIORITY_EN
    assign tie_to_1 = 1'b0;
    assign limit0   = 1'b0;
    // A pending port-0 request ends a port-1 burst at its next accepted beat.
    assign limit1   = (count == LAST_COUNT) || bus.req0;
`else
    logic last_served;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_served <= 1'b1;
        else if (fire0) last_served <= 1'b0;
        else if (fire1) last_served <= 1'b1;
    end

    assign tie_to_1 = !last_served;
    assign limit0   = (count == LAST_COUNT);
    assign limit1   = (count == LAST_COUNT);
`endif

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) state_nxt = tie_to_1 ? GNT1 : GNT0;
                else if (bus.req0)        state_nxt = GNT0;
                else if (bus.req1)        state_nxt = GNT1;
            end
            GNT0: begin
                if (fire0) count_nxt = count + 4'd1;
                if (!bus.req0 || (fire0 && limit0)) begin
                    count_nxt = '0;
                    if (bus.req1)      state_nxt = GNT1;
                    else if (bus.req0) state_nxt = GNT0;
                    else               state_nxt = IDLE;
                end
            end
            GNT1: begin
                if (fire1) count_nxt = count + 4'd1;
                if (!bus.req1 || (fire1 && limit1)) begin
                    count_nxt = '0;
                    if (bus.req0)      state_nxt = GNT0;
                    else if (bus.req1) state_nxt = GNT1;
                    else               state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (fire0 || fire1) begin
                q_r       <= fire1 ? bus.i1 : bus.i0;
                q_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                q_valid_r <= 1'b0;
            end
        end
    end

    assign bus.sel     = (state == GNT1);
    assign bus.grant0  = (state == GNT0);
    assign bus.grant1  = (state == GNT1);
    assign bus.ack0    = fire0;
    assign bus.ack1    = fire1;
    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed vector table, hand sequences, and random traffic vs an owner/beat model.
module tb_mux_rr_arbiter;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
`ifdef MUX_RR_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mux_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       r0, r1;
        logic [7:0] d0, d1;
        logic       rdy;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[20];

    // Reference model: who owns the mux, beats served this grant, last port served, output slot.
    int         m_own;
    int         m_beats;
    int         m_last;
    logic [7:0] m_q;
    bit         m_v;

    function automatic logic [13:0] ev(bit s, bit g0, bit g1, bit a0, bit a1, bit qv, logic [7:0] qq);
        return {s, g0, g1, a0, a1, qv, qq};
    endfunction

    function automatic vec_t mk(bit r0, bit r1, logic [7:0] d0, logic [7:0] d1, bit rdy, logic [13:0] e);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rdy = rdy; v.exp = e;
        return v;
    endfunction

    function automatic logic [13:0] dut_vec();
        return {bus.sel, bus.grant0, bus.grant1, bus.ack0, bus.ack1, bus.q_valid, bus.q};
    endfunction

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got {sel,g0,g1,a0,a1,qv,q}=%b_%h expected %b_%h",
                     name, act[13:8], act[7:0], exp[13:8], exp[7:0]);
        else
            n_pass++;
    endtask

    task automatic drive(input bit r0, input bit r1, input logic [7:0] d0, input logic [7:0] d1, input bit rdy);
        bus.req0 = r0; bus.req1 = r1; bus.i0 = d0; bus.i1 = d1; bus.out_ready = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_own = -1; m_beats = 0; m_last = 1; m_q = '0; m_v = 0;
    endtask

    task automatic do_reset();
        drive(0, 0, 8'd0, 8'd0, 1'b1);
        rst_n = 1'b0;
        model_reset();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
    endtask

    function automatic logic [13:0] model_out();
        bit free;
        bit a0, a1;
        free = !m_v || bus.out_ready;
        a0 = (m_own == 0) && bus.req0 && free;
        a1 = (m_own == 1) && bus.req1 && free;
        return ev(m_own == 1, m_own == 0, m_own == 1, a0, a1, m_v, m_q);
    endfunction

    task automatic model_edge();
        bit r[2];
        bit free, fired, done;
        int x;
        r[0] = bus.req0;
        r[1] = bus.req1;
        free = !m_v || bus.out_ready;
        x = m_own;
        fired = 0;
        if (x >= 0) fired = r[x] && free;
        if (fired) begin
            m_q = (x == 1) ? bus.i1 : bus.i0;
            m_v = 1;
            m_beats++;
            m_last = x;
        end else if (bus.out_ready) begin
            m_v = 0;
        end
        if (x < 0) begin
            if (r[0] && r[1]) m_own = FIXED ? 0 : 1 - m_last;
            else if (r[0])    m_own = 0;
            else if (r[1])    m_own = 1;
        end else begin
            done = !r[x]
                || (fired && m_beats == MAX_BURST && (!FIXED || x == 1))
                || (FIXED && x == 1 && fired && r[0]);
            if (done) begin
                m_beats = 0;
                if (r[1 - x])  m_own = 1 - x;
                else if (r[x]) m_own = x;
                else           m_own = -1;
            end
        end
    endtask

    initial begin
        bit r0, r1;
        int p;

        tbl[0]  = mk(1, 0, 100, 0,   1, ev(0, 0, 0, 0, 0, 0, 0));
        tbl[1]  = mk(1, 0, 100, 0,   1, ev(0, 1, 0, 1, 0, 0, 0));
        tbl[2]  = mk(0, 0, 0,   0,   1, ev(0, 1, 0, 0, 0, 1, 100));
        tbl[3]  = mk(0, 0, 0,   0,   1, ev(0, 0, 0, 0, 0, 0, 100));
        tbl[4]  = mk(0, 1, 0,   255, 1, ev(0, 0, 0, 0, 0, 0, 100));
        tbl[5]  = mk(0, 0, 0,   0,   1, ev(1, 0, 1, 0, 0, 0, 100));
        tbl[6]  = mk(0, 1, 0,   255, 1, ev(0, 0, 0, 0, 0, 0, 100));
        tbl[7]  = mk(0, 1, 0,   255, 1, ev(1, 0, 1, 0, 1, 0, 100));
        tbl[8]  = mk(0, 0, 0,   0,   1, ev(1, 0, 1, 0, 0, 1, 255));
        tbl[9]  = mk(1, 0, 7,   0,   1, ev(0, 0, 0, 0, 0, 0, 255));
        tbl[10] = mk(1, 0, 7,   0,   0, ev(0, 1, 0, 1, 0, 0, 255));
        tbl[11] = mk(1, 0, 8,   0,   0, ev(0, 1, 0, 0, 0, 1, 7));
        tbl[12] = mk(1, 0, 9,   0,   0, ev(0, 1, 0, 0, 0, 1, 7));
        tbl[13] = mk(1, 0, 10,  0,   0, ev(0, 1, 0, 0, 0, 1, 7));
        tbl[14] = mk(1, 0, 11,  0,   0, ev(0, 1, 0, 0, 0, 1, 7));
        tbl[15] = mk(1, 0, 12,  0,   0, ev(0, 1, 0, 0, 0, 1, 7));
        tbl[16] = mk(1, 0, 13,  0,   1, ev(0, 1, 0, 1, 0, 1, 7));
        tbl[17] = mk(1, 0, 14,  0,   1, ev(0, 1, 0, 1, 0, 1, 13));
        tbl[18] = mk(0, 0, 0,   0,   1, ev(0, 1, 0, 0, 0, 1, 14));
        tbl[19] = mk(0, 0, 0,   0,   1, ev(0, 0, 0, 0, 0, 0, 14));

        drive(0, 0, 8'd0, 8'd0, 1'b1);
        #2;
        chk("reset_state", dut_vec(), ev(0, 0, 0, 0, 0, 0, 0));

        // Directed table: single-port beat, one-cycle req pulse, backpressure freeze.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(tbl[k].r0, tbl[k].r1, tbl[k].d0, tbl[k].d1, tbl[k].rdy);
            #1;
            chk($sformatf("table[%0d]", k), dut_vec(), tbl[k].exp);
            next_cycle();
        end

`ifndef MUX_RR_FIXED_PRIORITY_EN
        // Both ports held: runs of MAX_BURST alternate with no idle cycle between them.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            drive(1, 1, 8'd39, 8'd24, 1'b1);
            #1;
            if (c == 0) begin
                chk("rr_c0", dut_vec(), ev(0, 0, 0, 0, 0, 0, 0));
            end else begin
                p = ((c - 1) / MAX_BURST) % 2;
                chk($sformatf("rr_c%0d", c), dut_vec(),
                    ev(p == 1, p == 0, p == 1, p == 0, p == 1, c >= 2,
                       (c < 2) ? 8'd0 : ((((c - 2) / MAX_BURST) % 2) == 1 ? 8'd24 : 8'd39)));
            end
            next_cycle();
        end
`else
        // Port 1 streaming is preempted after the beat in flight when req0 rises, and stays off while req0 holds.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(c >= 3, 1, 8'd60, 8'd50, 1'b1);
            #1;
            case (c)
                0:       chk("fp_c0", dut_vec(), ev(0, 0, 0, 0, 0, 0, 0));
                1:       chk("fp_c1", dut_vec(), ev(1, 0, 1, 0, 1, 0, 0));
                2, 3:    chk($sformatf("fp_c%0d", c), dut_vec(), ev(1, 0, 1, 0, 1, 1, 50));
                4:       chk("fp_c4", dut_vec(), ev(0, 1, 0, 1, 0, 1, 50));
                default: chk($sformatf("fp_c%0d", c), dut_vec(), ev(0, 1, 0, 1, 0, 1, 60));
            endcase
            next_cycle();
        end
`endif

        // Asynchronous reset while port 1 owns the mux with a valid beat in the slot.
        do_reset();
        drive(0, 1, 8'd0, 8'd77, 1'b1);
        next_cycle();
        next_cycle();
        #1;
        chk("pre_async_rst", dut_vec(), ev(1, 0, 1, 0, 1, 1, 77));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", dut_vec(), ev(0, 0, 0, 0, 0, 0, 0));
        #1;
        rst_n = 1'b1;
        drive(1, 1, 8'd5, 8'd6, 1'b1);
        next_cycle();
        #1;
        chk("post_rst_tie", dut_vec(), ev(0, 1, 0, 1, 0, 0, 0));
        next_cycle();

        // Random traffic with sticky requests against the reference model.
        do_reset();
        r0 = 0;
        r1 = 0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 4) == 0) r0 = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 4) == 0) r1 = $urandom_range(0, 1) == 1;
            drive(r0, r1, 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
            #1;
            chk($sformatf("rand_c%0d", c), dut_vec(), model_out());
            model_edge();
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
